// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each access takes three cycles: grant (IDLE), strobe (ACCESS), acknowledge (RESP).
module dmem_arbiter #(
  parameter int ADDR_MAX = 511
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               p0_req,
  input  logic               p0_rd,
  input  logic               p0_wr,
  input  logic signed [63:0] p0_addr,
  input  logic [63:0]        p0_wdata,
  output logic               p0_ack,
  output logic               p0_err,
  output logic [63:0]        p0_rdata,
  input  logic               p1_req,
  input  logic               p1_rd,
  input  logic               p1_wr,
  input  logic signed [63:0] p1_addr,
  input  logic [63:0]        p1_wdata,
  output logic               p1_ack,
  output logic               p1_err,
  output logic [63:0]        p1_rdata,
  output logic               read_enable,
  output logic               write_enable,
  output logic signed [63:0] mem_address,
  output logic [63:0]        mem_data,
  input  logic [63:0]        valM,
  input  logic               dmem_error
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cmd_t;

  localparam logic signed [63:0] AMAX = 64'(ADDR_MAX);

  state_t state;
  logic   last_p1;   // 1: port 1 was served last
  logic   port;      // port owning the access in flight
  logic   bad_q;
  logic   rd_q;

  cmd_t c0, c1, win;
  logic sel, bad;

  assign c0 = '{rd: p0_rd, wr: p0_wr, addr: p0_addr, wdata: p0_wdata};
  assign c1 = '{rd: p1_rd, wr: p1_wr, addr: p1_addr, wdata: p1_wdata};

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  always_comb begin
    sel = p1_req & (~p0_req | ~last_p1);
    win = sel ? c1 : c0;
    bad = ($signed(win.addr) < 64'sd0) || ($signed(win.addr) > AMAX) || (win.rd == win.wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_p1      <= 1'b1;
      port         <= 1'b0;
      bad_q        <= 1'b0;
      rd_q         <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      mem_address  <= '0;
      mem_data     <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            port         <= sel;
            bad_q        <= bad;
            rd_q         <= win.rd;
            mem_address  <= win.addr;
            mem_data     <= win.wdata;
            read_enable  <= ~bad & win.rd;
            write_enable <= ~bad & win.wr;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // valM and dmem_error reflect mem_address during the strobe cycle
          if (!port) begin
            p0_err <= bad_q | dmem_error;
            if (rd_q && !bad_q) p0_rdata <= valM;
          end else begin
            p1_err <= bad_q | dmem_error;
            if (rd_q && !bad_q) p1_rdata <= valM;
          end
          state <= RESP;
        end
        RESP: begin
          p0_ack  <= ~port;
          p1_ack  <= port;
          last_p1 <= port;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p0_req = 0, p0_rd = 0, p0_wr = 0, p1_req = 0, p1_rd = 0, p1_wr = 0;
  logic signed [63:0] p0_addr = 0, p1_addr = 0;
  logic [63:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_ack, p0_err, p1_ack, p1_err, read_enable, write_enable, dmem_error;
  logic [63:0] p0_rdata, p1_rdata, mem_data, valM;
  logic signed [63:0] mem_address;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_MAX(511)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .read_enable(read_enable), .write_enable(write_enable),
    .mem_address(mem_address), .mem_data(mem_data),
    .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, write on the clock edge.
  logic [63:0] mem [0:511];
  logic [63:0] ref_mem [0:511];
  logic in_rng;
  assign in_rng     = (mem_address >= 64'sd0) && (mem_address <= 64'sd511);
  assign valM       = in_rng ? mem[mem_address[8:0]] : 64'h0;
  assign dmem_error = ~in_rng;
  always @(posedge clk) if (write_enable && in_rng) mem[mem_address[8:0]] <= mem_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a grant at edge g means strobes in cycle g, ack in cycle g+2,
  // and the arbiter is free again at edge g+3.
  int ecount = 0, g_edge = -100, free_at = 0, g_port = 0, k_c;
  logic g_re, g_we, g_err, m_last = 1'b1, m_rd, m_wr;
  logic signed [63:0] g_addr, m_a;
  logic [63:0] g_wdata, g_rdata;
  logic [63:0] e_rd [2];
  logic        e_er [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_edge = -100; free_at = 0; m_last = 1'b1;
      g_re = 0; g_we = 0;
      e_rd[0] = 0; e_rd[1] = 0; e_er[0] = 0; e_er[1] = 0;
    end else begin
      ecount++;
      if (ecount == g_edge + 1 && g_we) ref_mem[g_addr[8:0]] = g_wdata;
      if (ecount == g_edge + 2) begin
        e_rd[g_port] = g_rdata;
        e_er[g_port] = g_err;
      end
      if (ecount >= free_at && (p0_req || p1_req)) begin
        g_port = (p0_req && p1_req) ? (m_last ? 0 : 1) : (p1_req ? 1 : 0);
        m_last = (g_port == 1);
        m_a    = g_port ? p1_addr : p0_addr;
        m_rd   = g_port ? p1_rd : p0_rd;
        m_wr   = g_port ? p1_wr : p0_wr;
        g_wdata = g_port ? p1_wdata : p0_wdata;
        g_addr = m_a;
        g_err  = !(m_a >= 0 && m_a <= 511 && m_rd != m_wr);
        g_re   = !g_err && m_rd;
        g_we   = !g_err && m_wr;
        g_rdata = g_re ? ref_mem[m_a[8:0]] : e_rd[g_port];
        g_edge = ecount;
        free_at = ecount + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      k_c = ecount - g_edge;
      chk("read_enable", read_enable, (k_c == 0) && g_re);
      chk("write_enable", write_enable, (k_c == 0) && g_we);
      if (k_c == 0 && (g_re || g_we)) chk("mem_address", mem_address, g_addr);
      if (k_c == 0 && g_we) chk("mem_data", mem_data, g_wdata);
      chk("p0_ack", p0_ack, (k_c == 2) && (g_port == 0));
      chk("p1_ack", p1_ack, (k_c == 2) && (g_port == 1));
      if (k_c == 2) begin
        chk("p0_rdata", p0_rdata, e_rd[0]);
        chk("p1_rdata", p1_rdata, e_rd[1]);
        chk("p0_err", p0_err, e_er[0]);
        chk("p1_err", p1_err, e_er[1]);
      end
    end else begin
      chk("rst_ctl", {read_enable, write_enable, p0_ack, p1_ack, p0_err, p1_err}, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
      chk("rst_bus", mem_address | mem_data, 0);
    end
  end

  task automatic txn(input int p, input logic rd, input logic wr, input logic signed [63:0] a,
                     input logic [63:0] d, output int lat);
    logic got;
    got = 0; lat = -1;
    if (p == 0) begin p0_rd = rd; p0_wr = wr; p0_addr = a; p0_wdata = d; p0_req = 1; end
    else        begin p1_rd = rd; p1_wr = wr; p1_addr = a; p1_wdata = d; p1_req = 1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if ((p == 0) ? p0_ack : p1_ack) begin got = 1; lat = i; end
    end
    chk("ack_timeout", got, 1);
    if (p == 0) p0_req = 0; else p1_req = 0;
  endtask

  task automatic rnd_cmd(output logic rd, output logic wr, output logic signed [63:0] a,
                         output logic [63:0] d);
    int r, r2;
    r = $urandom_range(9);
    r2 = $urandom_range(7);
    case (r)
      0: a = -64'sd1;
      1: a = 64'sd512;
      2: a = 64'sd511;
      3: a = 64'sd0;
      default: a = 64'($urandom_range(511));
    endcase
    if (r2 == 0)      begin rd = 1; wr = 1; end
    else if (r2 == 1) begin rd = 0; wr = 0; end
    else              begin rd = r2[0]; wr = ~r2[0]; end
    d = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bad, c;
    logic seen;
    int aq_p[$], aq_c[$];
    for (int i = 0; i < 512; i++) begin mem[i] = 64'(i * 3 + 1); ref_mem[i] = 64'(i * 3 + 1); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Write then read back on port 0
    txn(0, 0, 1, 5, 64'hDEAD, lat);
    chk("first_latency", lat, 2);
    chk("wr5_err", p0_err, 0);
    txn(0, 1, 0, 5, 0, lat);
    chk("rd5_data", p0_rdata, 64'hDEAD);
    chk("rd5_err", p0_err, 0);

    // Port 1 read so that port 0 wins the following tie
    txn(1, 1, 0, 30, 0, lat);
    chk("p1_rd30", p1_rdata, 64'd91);

    // Held tie: grants alternate, acks 3 cycles apart
    p0_rd = 1; p0_wr = 0; p0_addr = 10; p1_rd = 1; p1_wr = 0; p1_addr = 20;
    p0_req = 1; p1_req = 1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (p0_ack) begin aq_p.push_back(0); aq_c.push_back(i); end
      if (p1_ack) begin aq_p.push_back(1); aq_c.push_back(i); end
    end
    p0_req = 0; p1_req = 0;
    chk("tie_count", aq_p.size(), 4);
    for (int i = 0; i < aq_p.size() && i < 4; i++) begin
      chk("tie_order", aq_p[i], i % 2);
      if (i > 0) chk("tie_spacing", aq_c[i] - aq_c[i-1], 3);
    end
    chk("tie_p0_data", p0_rdata, 64'd31);
    chk("tie_p1_data", p1_rdata, 64'd61);

    // Illegal commands on port 1 leave rdata alone
    txn(1, 1, 0, -64'sd1, 0, lat);
    chk("neg_err", p1_err, 1);
    chk("neg_rdata", p1_rdata, 64'd61);
    txn(1, 1, 0, 64'sd512, 0, lat);
    chk("oob_err", p1_err, 1);
    chk("oob_rdata", p1_rdata, 64'd61);
    txn(1, 1, 1, 64'sd5, 0, lat);
    chk("rdwr_err", p1_err, 1);
    chk("rdwr_rdata", p1_rdata, 64'd61);

    // Address boundary on port 0
    txn(0, 1, 0, 64'sd511, 0, lat);
    chk("a511_err", p0_err, 0);
    chk("a511_data", p0_rdata, 64'd1534);
    txn(0, 0, 1, 64'sd512, 64'h1234, lat);
    chk("a512_err", p0_err, 1);
    chk("a512_rdata", p0_rdata, 64'd1534);

    // Port 1 drops req mid-access while port 0 inputs churn
    p1_rd = 0; p1_wr = 1; p1_addr = 77; p1_wdata = 64'hCAFE0077; p1_req = 1;
    @(posedge clk); #1;
    p1_req = 0; p1_addr = 3; p1_wdata = 0; p1_wr = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      p0_rd = 1'($urandom); p0_wr = 1'($urandom); p0_addr = 64'($urandom_range(600)); p0_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      if (p1_ack) seen = 1;
    end
    chk("drop_ack", seen, 1);
    chk("drop_mem77", mem[77], 64'hCAFE0077);

    // Reset during the write strobe
    p0_rd = 0; p0_wr = 1; p0_addr = 9; p0_wdata = 64'h99; p0_req = 1;
    @(posedge clk); #1;
    chk("we_pre_rst", write_enable, 1);
    rst_n = 0;
    #1;
    chk("we_async_drop", write_enable, 0);
    p0_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("mem9_kept", mem[9], 64'd28);
    p0_rd = 1; p0_wr = 0; p0_addr = 40; p1_rd = 1; p1_wr = 0; p1_addr = 50;
    p0_req = 1; p1_req = 1;
    @(posedge clk); #1;
    chk("rst_tie_addr", mem_address, 64'd40);
    chk("rst_tie_re", read_enable, 1);
    p0_req = 0; p1_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tie_ack", p0_ack, 1);
    chk("rst_tie_data", p0_rdata, 64'd121);

    // Random traffic against the model
    c = 0;
    while (c < 450) begin
      @(posedge clk); #1;
      if (p0_ack) begin
        if ($urandom_range(2) == 0) p0_req = 0; else rnd_cmd(p0_rd, p0_wr, p0_addr, p0_wdata);
      end else if (!p0_req) begin
        rnd_cmd(p0_rd, p0_wr, p0_addr, p0_wdata);
        if ($urandom_range(2) == 0) p0_req = 1;
      end
      if (p1_ack) begin
        if ($urandom_range(2) == 0) p1_req = 0; else rnd_cmd(p1_rd, p1_wr, p1_addr, p1_wdata);
      end else if (!p1_req) begin
        rnd_cmd(p1_rd, p1_wr, p1_addr, p1_wdata);
        if ($urandom_range(2) == 0) p1_req = 1;
      end
      c++;
    end
    p0_req = 0; p1_req = 0;
    repeat (6) @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
